// File: rtl/zeroriscy_if_aligner_pkg.sv
// zeroriscy_defines: shared aligner state type and RVC opcode mask
// Imported by the fetch FIFO and the aligner top. This package has no ports.
package zeroriscy_defines;
    typedef enum logic {ALIGNED, UNALIGNED} aligner_state_e;
    localparam logic [1:0] OPCODE_C_MASK = 2'b11;
endpackage

// File: rtl/zeroriscy_if_aligner_if.sv
// zeroriscy_if_aligner_if: instruction memory port bundle
// Signals:
//   req, addr      - request and word address (from the fetch unit)
//   gnt            - request accepted (from memory)
//   rvalid, rdata  - response valid and data (from memory)
//   err            - response error (from memory), only with ZERORISCY_IF_FETCH_ERR_EN
// Modports: master = fetch unit side, slave = memory side.
interface zeroriscy_if_aligner_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
`ifdef ZERORISCY_IF_FETCH_ERR_EN
    logic        err;
`endif
    modport master (
        output req, addr,
`ifdef ZERORISCY_IF_FETCH_ERR_EN
        input  err,
`endif
        input  gnt, rvalid, rdata
    );
    modport slave (
        input  req, addr,
`ifdef ZERORISCY_IF_FETCH_ERR_EN
        output err,
`endif
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/zeroriscy_if_aligner_fifo.sv
// zeroriscy_fetch_fifo: circular buffer of fetched words with lookahead
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   push, pop, flush    - write data, drop head, empty the buffer (flush wins)
//   data                - word to write
//   count               - number of stored words
//   head, head1         - oldest word and the one after it
//   err, head_err, head1_err - per-entry error bit, only with ZERORISCY_IF_FETCH_ERR_EN
// Pointers wrap at DEPTH, which need not be a power of two.
module zeroriscy_fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [31:0]                  data,
`ifdef ZERORISCY_IF_FETCH_ERR_EN
    input  logic                         err,
    output logic                         head_err,
    output logic                         head1_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [31:0]                  head,
    output logic [31:0]                  head1
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd, wr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            rd    <= pop ? inc(rd) : rd;
            wr    <= push ? inc(wr) : wr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr] <= data;
    end
    assign head  = mem[rd];
    assign head1 = mem[inc(rd)];
`ifdef ZERORISCY_IF_FETCH_ERR_EN
    logic err_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (push && !flush) err_mem[wr] <= err;
    end
    assign head_err  = err_mem[rd];
    assign head1_err = err_mem[inc(rd)];
`endif
endmodule

// File: rtl/zeroriscy_if_aligner.sv
// zeroriscy_if_aligner: prefetching RV32C instruction fetch and realignment front end
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   req_i                     - fetch enable
//   branch_i, branch_addr_i   - redirect pulse and target
//   bus (master)              - instruction memory port
//   valid_o, ready_i          - instruction handshake towards IF/ID
//   instr_o, is_compressed_o  - raw instruction (RVC zero-extended) and its kind
//   pc_o                      - PC of instr_o
//   busy_o                    - requests outstanding or being issued
//   err_o                     - fetch error on a contributing word, only with ZERORISCY_IF_FETCH_ERR_EN
// Optional feature macro: ZERORISCY_IF_FETCH_ERR_EN.
module zeroriscy_if_aligner
    import zeroriscy_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_i,
    input  logic                   branch_i,
    input  logic [31:0]            branch_addr_i,
    zeroriscy_if_aligner_if.master bus,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [31:0]            instr_o,
    output logic                   is_compressed_o,
    output logic [31:0]            pc_o,
`ifdef ZERORISCY_IF_FETCH_ERR_EN
    output logic                   err_o,
`endif
    output logic                   busy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    aligner_state_e state_q, state_d;
    logic [31:0]   faddr_q, pc_q, pc_d, w, w2, raw;
    logic [CW-1:0] outstanding_q, discard_q, fifo_count;
    logic [CW:0]   inflight;
    logic          started_q, gnt, push, pop, hs, half_c, avail, unused_bits;
    // Every outstanding request owns a future FIFO slot, so capping the sum keeps the FIFO from overflowing.
    assign inflight    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign bus.req     = req_i & ~branch_i & started_q & (inflight < DEPTH_W);
    assign bus.addr    = faddr_q;
    assign gnt         = bus.req & bus.gnt;
    assign push        = bus.rvalid & (discard_q == '0) & ~branch_i;
    assign busy_o      = (outstanding_q != '0) | bus.req;
    assign unused_bits = ^{branch_addr_i[0], w2[31:16]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            faddr_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            started_q     <= 1'b0;
        end else begin
            faddr_q       <= branch_i ? {branch_addr_i[31:2], 2'b00} : gnt ? faddr_q + 32'd4 : faddr_q;
            outstanding_q <= outstanding_q + CW'(gnt) - CW'(bus.rvalid);
            // A response arriving in the branch cycle is already dropped by the flush, so it is not counted.
            discard_q     <= branch_i ? outstanding_q - CW'(bus.rvalid) :
                             (bus.rvalid && discard_q != '0) ? discard_q - CW'(1) : discard_q;
            started_q     <= started_q | branch_i;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    always_comb begin
        half_c  = (state_q == ALIGNED ? w[1:0] : w[17:16]) != OPCODE_C_MASK;
        // A straddling instruction needs its upper half from the next word as well.
        avail   = (state_q == UNALIGNED && !half_c) ? (fifo_count > CW'(1)) : (fifo_count != '0);
        raw     = state_q == ALIGNED ? (half_c ? {16'h0, w[15:0]} : w) :
                  (half_c ? {16'h0, w[31:16]} : {w2[15:0], w[31:16]});
        valid_o = avail & ~branch_i;
        hs      = valid_o & ready_i;
        // A compressed lower half leaves the upper half of the same word still to be consumed.
        pop     = hs & (state_q == UNALIGNED | ~half_c);
        state_d = state_q;
        pc_d    = pc_q;
        if (branch_i) begin
            state_d = branch_addr_i[1] ? UNALIGNED : ALIGNED;
            pc_d    = {branch_addr_i[31:1], 1'b0};
        end else if (hs) begin
            state_d = half_c ? (state_q == ALIGNED ? UNALIGNED : ALIGNED) : state_q;
            pc_d    = pc_q + (half_c ? 32'd2 : 32'd4);
        end
    end
    assign instr_o         = valid_o ? raw : '0;
    assign is_compressed_o = valid_o & half_c;
    assign pc_o            = pc_q;
`ifdef ZERORISCY_IF_FETCH_ERR_EN
    logic e, e2;
    assign err_o = valid_o & (e | (state_q == UNALIGNED & ~half_c & e2));
`endif
    zeroriscy_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (branch_i),
        .data     (bus.rdata),
`ifdef ZERORISCY_IF_FETCH_ERR_EN
        .err      (bus.err),
        .head_err (e),
        .head1_err(e2),
`endif
        .count    (fifo_count),
        .head     (w),
        .head1    (w2)
    );
endmodule
